// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, no parity, 1 or 2 stop bits.
// Outputs are registered decodes of the state, so the line lags the state by one clk.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_data_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_cnt;
  logic              stop_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              bit_end;
  logic              in_frame;

  assign bit_end  = (baud_cnt == '0);
  assign in_frame = (state == START) || (state == DATA) || (state == STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      baud_cnt    <= BAUD_RELOAD;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else if (soft_rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      baud_cnt    <= BAUD_RELOAD;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_start) begin
            shift_reg <= tx_data_in;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) state <= DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              stop_cnt <= 1'b0;
              state    <= DONE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Baud counter reloads at every bit boundary and parks at the reload value outside a frame
      if (in_frame) baud_cnt <= bit_end ? BAUD_RELOAD : baud_cnt - 1'b1;
      else          baud_cnt <= BAUD_RELOAD;

      case (state)
        START:   tx_data_out <= 1'b0;
        DATA:    tx_data_out <= shift_reg[0];
        default: tx_data_out <= 1'b1;
      endcase
      tx_busy <= in_frame;
      tx_done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: waveform model driven from frame timing rules,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       line1, busy1, done1;
  logic       line2, busy2, done2;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_data_out(line1), .tx_busy(busy1), .tx_done(done1)
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .tx_start(tx_start),
    .tx_data_in(tx_data_in), .tx_data_out(line2), .tx_busy(busy2), .tx_done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {line, busy, done} k edges after the accepting edge (k<=0: idle)
  function automatic logic [2:0] exp_out(input int k, input logic [7:0] d, input int s);
    int l;
    l = (9 + s) * C + 1;
    if (k <= 0) return 3'b100;
    if (k <= C) return 3'b010;
    if (k <= 9 * C) return {d[(k - C - 1) / C], 2'b10};
    if (k < l) return 3'b110;
    return 3'b101;
  endfunction

  function automatic int next_k(input int k, input logic st, input int s);
    int l;
    l = (9 + s) * C + 1;
    if (k == -1 || k == l) return st ? 0 : -1;
    return k + 1;
  endfunction

  int         k1 = -1, k2 = -1;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst || soft_rst) begin
      k1 = -1;
      k2 = -1;
    end else begin
      k1 = next_k(k1, tx_start, 1);
      if (k1 == 0) d1 = tx_data_in;
      k2 = next_k(k2, tx_start, 2);
      if (k2 == 0) d2 = tx_data_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_s1", 32'({line1, busy1, done1}), 32'(exp_out(k1, d1, 1)));
      check("model_s2", 32'({line2, busy2, done2}), 32'(exp_out(k2, d2, 2)));
    end
  end

  // Sends one byte and observes one DUT for 60 samples; optional mid-frame injection
  task automatic run_frame(input logic [7:0] d, input int which, input int inj_k, input int inj_kind,
                           output logic [7:0] got, output int done_k, output int done_cnt,
                           output int busy_cnt, output int hi_stop, output logic line_end,
                           output logic [2:0] post_inj);
    logic ln, bz, dn;
    got = 8'h00; done_k = -1; done_cnt = 0; busy_cnt = 0; hi_stop = 0;
    line_end = 1'b0; post_inj = 3'b000;
    @(posedge clk); #2;
    tx_start = 1'b1; tx_data_in = d;
    @(posedge clk); #2;
    tx_start = 1'b0; tx_data_in = 8'($urandom);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      ln = (which == 2) ? line2 : line1;
      bz = (which == 2) ? busy2 : busy1;
      dn = (which == 2) ? done2 : done1;
      if (bz) busy_cnt++;
      if (dn) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k >= C + 3 && k <= 9 * C + 2 && ((k - C - 3) % C) == 0) got[(k - C - 3) / C] = ln;
      if (k >= 9 * C + 1 && k <= 9 * C + 8 && ln) hi_stop++;
      if (k == inj_k + 1) post_inj = {ln, bz, dn};
      if (k == 59) line_end = ln;
      tx_data_in = 8'($urandom);
      if (k == inj_k) begin
        if (inj_kind == 1) begin
          tx_start = 1'b1;
          tx_data_in = 8'h55;
        end else if (inj_kind == 2) begin
          soft_rst = 1'b1;
        end
      end else if (k == inj_k + 1) begin
        tx_start = 1'b0;
        soft_rst = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] got, bytes [3];
    int done_k, done_cnt, busy_cnt, hi_stop;
    logic line_end;
    logic [2:0] post;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({line1, busy1, done1, line2, busy2, done2}), 32'(6'b100100));
    @(posedge clk); #2;
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    run_frame(8'hA5, 1, -5, 0, got, done_k, done_cnt, busy_cnt, hi_stop, line_end, post);
    check("a5_byte", 32'(got), 32'h A5);
    check("a5_done_cycle", 32'(done_k), 32'd41);
    check("a5_busy_cycles", 32'(busy_cnt), 32'd40);
    check("a5_done_count", 32'(done_cnt), 32'd1);
    check("a5_stop_high", 32'(hi_stop), 32'd8);

    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      run_frame(bytes[i], 1, -5, 0, got, done_k, done_cnt, busy_cnt, hi_stop, line_end, post);
      check("loop_byte", 32'(got), 32'(bytes[i]));
      check("loop_done", 32'(done_cnt), 32'd1);
    end

    run_frame(8'h0F, 1, 10, 1, got, done_k, done_cnt, busy_cnt, hi_stop, line_end, post);
    check("ignore_byte", 32'(got), 32'h0F);
    check("ignore_done", 32'(done_cnt), 32'd1);
    check("ignore_line_end", 32'(line_end), 32'd1);

    run_frame(8'hC3, 1, 18, 2, got, done_k, done_cnt, busy_cnt, hi_stop, line_end, post);
    check("abort_outputs", 32'(post), 32'(3'b100));
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame(8'h81, 1, -5, 0, got, done_k, done_cnt, busy_cnt, hi_stop, line_end, post);
    check("after_abort_byte", 32'(got), 32'h81);
    check("after_abort_done", 32'(done_k), 32'd41);

    run_frame(8'h80, 2, -5, 0, got, done_k, done_cnt, busy_cnt, hi_stop, line_end, post);
    check("s2_byte", 32'(got), 32'h80);
    check("s2_done_cycle", 32'(done_k), 32'd45);
    check("s2_busy_cycles", 32'(busy_cnt), 32'd44);
    check("s2_stop_high", 32'(hi_stop), 32'd8);

    // Asynchronous reset in the middle of a data bit
    @(posedge clk); #2;
    tx_start = 1'b1; tx_data_in = 8'h00;
    @(posedge clk); #2;
    tx_start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst", 32'({line1, busy1, done1, line2, busy2, done2}), 32'(6'b100100));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      tx_start   = ($urandom_range(0, 3) == 0);
      tx_data_in = 8'($urandom);
      soft_rst   = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #2;
    tx_start = 1'b0;
    soft_rst = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
